// File: rtl/booth_arb_pkg.sv
// booth_arb_pkg: shared widths, iteration count and FSM encoding for the Booth multiplier arbiter.
package booth_arb_pkg;
  localparam int OP_W = 4;
  localparam int PROD_W = 8;
  localparam int ITERATIONS = 4;
  typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;
endpackage

// File: rtl/booth_step.sv
// booth_step: one radix-2 Booth iteration (add/subtract M, then arithmetic right shift of {A, Q, Q-1}).
module booth_step
  import booth_arb_pkg::*;
(
  input  logic [OP_W:0]   i_a,
  input  logic [OP_W-1:0] i_q,
  input  logic            i_q1,
  input  logic [OP_W-1:0] i_m,
  output logic [OP_W:0]   o_a,
  output logic [OP_W-1:0] o_q,
  output logic            o_q1
);
  // A carries one guard bit so that subtracting M = -2^(OP_W-1) cannot overflow.
  logic [OP_W:0] w_m;
  logic [OP_W:0] w_sum;
  assign w_m = {i_m[OP_W-1], i_m};
  assign w_sum = ({i_q[0], i_q1} == 2'b01) ? i_a + w_m :
                 ({i_q[0], i_q1} == 2'b10) ? i_a + ~w_m + (OP_W+1)'(1) : i_a;
  assign o_a = {w_sum[OP_W], w_sum[OP_W:1]};
  assign o_q = {w_sum[0], i_q[OP_W-1:1]};
  assign o_q1 = i_q[0];
endmodule

// File: rtl/booth_mult_arbiter.sv
// booth_mult_arbiter: two-requester round-robin front end to a 4x4 signed radix-2 Booth multiplier.
// Define BOOTH_ARB_CYCLE_COUNT_EN to enable the iteration-cycle counter on cycle_count.
module booth_mult_arbiter
  import booth_arb_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  input  logic              req1_valid,
  output logic              req0_ready,
  output logic              req1_ready,
  input  logic [OP_W-1:0]   req0_mcand,
  input  logic [OP_W-1:0]   req0_mplier,
  input  logic [OP_W-1:0]   req1_mcand,
  input  logic [OP_W-1:0]   req1_mplier,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [PROD_W-1:0] rsp_product,
  output logic              rsp_id,
  output logic              busy,
  output logic [7:0]        cycle_count
);
  localparam int CNT_W = $clog2(ITERATIONS + 1);
  state_t           r_state;
  logic [OP_W:0]    r_a;
  logic [OP_W-1:0]  r_q;
  logic [OP_W-1:0]  r_m;
  logic             r_q1;
  logic [CNT_W-1:0] r_cnt;
  logic             r_id;
  logic             r_last;
  logic             w_grant;
  logic             w_idle;
  logic             w_acc;
  logic [OP_W:0]    w_a;
  logic [OP_W-1:0]  w_q;
  logic             w_q1;
  // On a tie the requester that did not win last time is granted.
  assign w_grant = (req0_valid & req1_valid) ? ~r_last : req1_valid;
  assign w_idle = (r_state == IDLE) & ~rst;
  assign req0_ready = w_idle & req0_valid & ~w_grant;
  assign req1_ready = w_idle & req1_valid & w_grant;
  assign w_acc = req0_ready | req1_ready;
  assign rsp_valid = (r_state == DONE);
  assign busy = (r_state != IDLE);
  assign rsp_product = {r_a[OP_W-1:0], r_q};
  assign rsp_id = r_id;
  booth_step u_step (
    .i_a  (r_a),
    .i_q  (r_q),
    .i_q1 (r_q1),
    .i_m  (r_m),
    .o_a  (w_a),
    .o_q  (w_q),
    .o_q1 (w_q1)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_a <= '0;
      r_q <= '0;
      r_m <= '0;
      r_q1 <= 1'b0;
      r_cnt <= '0;
      r_id <= 1'b0;
      r_last <= 1'b1;
    end else begin
      case (r_state)
        IDLE: if (w_acc) begin
          r_state <= ITER;
          r_m <= w_grant ? req1_mcand : req0_mcand;
          r_q <= w_grant ? req1_mplier : req0_mplier;
          r_a <= '0;
          r_q1 <= 1'b0;
          r_cnt <= CNT_W'(ITERATIONS);
          r_id <= w_grant;
          r_last <= w_grant;
        end
        ITER: begin
          r_a <= w_a;
          r_q <= w_q;
          r_q1 <= w_q1;
          r_cnt <= r_cnt - CNT_W'(1);
          if (r_cnt == CNT_W'(1)) r_state <= DONE;
        end
        DONE: if (rsp_ready) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end
`ifdef BOOTH_ARB_CYCLE_COUNT_EN
  logic [7:0] r_cycles;
  always_ff @(posedge clk) begin
    if (rst) r_cycles <= '0;
    else if (w_acc) r_cycles <= '0;
    else if (r_state == ITER) r_cycles <= r_cycles + 8'd1;
  end
  assign cycle_count = r_cycles;
`else
  assign cycle_count = '0;
`endif
endmodule

// File: tb/tb_booth_mult_arbiter.sv
// tb_booth_mult_arbiter: scoreboard bench for the Booth multiplier arbiter.
module tb_booth_mult_arbiter;
  logic clk = 1'b0;
  logic rst;
  logic req0_valid, req1_valid, req0_ready, req1_ready;
  logic [3:0] req0_mcand, req0_mplier, req1_mcand, req1_mplier;
  logic rsp_valid, rsp_ready, rsp_id, busy;
  logic [7:0] rsp_product, cycle_count;
  int total = 0;
  int bad = 0;
  logic [8:0] sb[$];
`ifdef BOOTH_ARB_CYCLE_COUNT_EN
  localparam logic [7:0] EXP_CC = 8'd4;
`else
  localparam logic [7:0] EXP_CC = 8'd0;
`endif

  booth_mult_arbiter dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req1_valid(req1_valid),
    .req0_ready(req0_ready), .req1_ready(req1_ready),
    .req0_mcand(req0_mcand), .req0_mplier(req0_mplier),
    .req1_mcand(req1_mcand), .req1_mplier(req1_mplier),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_product(rsp_product), .rsp_id(rsp_id),
    .busy(busy), .cycle_count(cycle_count)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] model(input logic [3:0] a, input logic [3:0] b);
    int p;
    p = $signed(a) * $signed(b);
    return p[7:0];
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit id, input logic [3:0] mc, input logic [3:0] mp);
    if (id) begin
      req1_valid = 1'b1; req1_mcand = mc; req1_mplier = mp;
    end else begin
      req0_valid = 1'b1; req0_mcand = mc; req0_mplier = mp;
    end
  endtask

  task automatic scramble;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_mcand = 4'($urandom); req0_mplier = 4'($urandom);
    req1_mcand = 4'($urandom); req1_mplier = 4'($urandom);
  endtask

  task automatic wait_accept(output bit ok, output bit who, output bit both, output int waited);
    ok = 0; who = 0; both = 0; waited = 0;
    for (int n = 0; n < 30 && !ok; n++) begin
      #1;
      if (req0_ready && req1_ready) both = 1;
      if (req0_ready || req1_ready) begin
        ok = 1; who = req1_ready; waited = n;
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_rsp(output bit ok, output int lat);
    ok = 0; lat = 0;
    for (int n = 1; n <= 30 && !ok; n++) begin
      tick;
      if (rsp_valid) begin ok = 1; lat = n; end
    end
  endtask

  task automatic ack;
    rsp_ready = 1'b1;
    tick;
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; req0_valid = 1'b1; req1_valid = 1'b1;
    tick;
    total++;
    if ({req0_ready, req1_ready, rsp_valid, busy} !== 4'b0) begin
      bad++; $display("FAIL reset_ctrl: got rdy0/rdy1/vld/busy=%b want 0000", {req0_ready, req1_ready, rsp_valid, busy});
    end
    total++;
    if ({rsp_id, rsp_product} !== 9'h0) begin
      bad++; $display("FAIL reset_rsp: got id=%0d prod=%h want id=0 prod=00", rsp_id, rsp_product);
    end
    total++;
    if (cycle_count !== 8'd0) begin
      bad++; $display("FAIL reset_cc: got %0d want 0", cycle_count);
    end
    req0_valid = 1'b0; req1_valid = 1'b0; rst = 1'b0;
    tick;
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL reset_idle: got busy=%b want 0", busy); end
  endtask

  task automatic test_basic;
    bit ok, who, both;
    int w, lat;
    logic [8:0] e;
    drive(0, 4'b1010, 4'b0110);
    wait_accept(ok, who, both, w);
    total++;
    if (!ok || who !== 1'b0 || w != 0) begin
      bad++; $display("FAIL basic_accept: got ok=%0d who=%0d wait=%0d want 1 0 0", ok, who, w);
    end
    sb.push_back({1'b0, 8'b1101_1100});
    scramble;
    wait_rsp(ok, lat);
    total++;
    if (!ok || lat != 4) begin bad++; $display("FAIL basic_latency: got ok=%0d lat=%0d want 1 4", ok, lat); end
    total++;
    if (sb.size() == 0) begin bad++; $display("FAIL basic_rsp: got no expected entry"); end
    else begin
      e = sb.pop_front();
      if ({rsp_id, rsp_product} !== e) begin
        bad++; $display("FAIL basic_rsp: got id=%0d prod=%h want id=%0d prod=%h", rsp_id, rsp_product, e[8], e[7:0]);
      end
    end
    total++;
    if (cycle_count !== EXP_CC) begin bad++; $display("FAIL basic_cc: got %0d want %0d", cycle_count, EXP_CC); end
    ack;
    total++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL basic_ack: got vld=%b busy=%b want 0 0", rsp_valid, busy);
    end
  endtask

  task automatic test_req1;
    logic [3:0] mc[2] = '{4'b1000, 4'b1000};
    logic [3:0] mp[2] = '{4'b0001, 4'b1000};
    logic [7:0] ep[2] = '{8'b1111_1000, 8'b0100_0000};
    bit ok, who, both;
    int w, lat;
    logic [8:0] e;
    for (int k = 0; k < 2; k++) begin
      drive(1, mc[k], mp[k]);
      wait_accept(ok, who, both, w);
      total++;
      if (!ok || who !== 1'b1) begin bad++; $display("FAIL req1_accept%0d: got ok=%0d who=%0d want 1 1", k, ok, who); end
      sb.push_back({1'b1, ep[k]});
      scramble;
      wait_rsp(ok, lat);
      total++;
      if (sb.size() == 0) begin bad++; $display("FAIL req1_rsp%0d: got no expected entry", k); end
      else begin
        e = sb.pop_front();
        if (!ok || lat != 4 || {rsp_id, rsp_product} !== e) begin
          bad++; $display("FAIL req1_rsp%0d: got lat=%0d id=%0d prod=%h want lat=4 id=%0d prod=%h", k, lat, rsp_id, rsp_product, e[8], e[7:0]);
        end
      end
      ack;
    end
  endtask

  task automatic test_round_robin;
    logic [3:0] mc0 = 4'd3, mp0 = 4'b1011, mc1 = 4'b1001, mp1 = 4'd2;
    bit ok, who, both;
    int w, lat;
    logic [8:0] e;
    rst = 1'b1; tick; rst = 1'b0;
    drive(0, mc0, mp0);
    drive(1, mc1, mp1);
    for (int k = 0; k < 4; k++) begin
      wait_accept(ok, who, both, w);
      total++;
      if (!ok || both || who !== 1'(k)) begin
        bad++; $display("FAIL rr_grant%0d: got ok=%0d both=%0d who=%0d want 1 0 %0d", k, ok, both, who, k % 2);
      end
      sb.push_back(who ? {1'b1, model(mc1, mp1)} : {1'b0, model(mc0, mp0)});
      wait_rsp(ok, lat);
      total++;
      if (sb.size() == 0) begin bad++; $display("FAIL rr_rsp%0d: got no expected entry", k); end
      else begin
        e = sb.pop_front();
        if (!ok || {rsp_id, rsp_product} !== e || req0_ready || req1_ready) begin
          bad++; $display("FAIL rr_rsp%0d: got id=%0d prod=%h rdy=%b%b want id=%0d prod=%h rdy=00", k, rsp_id, rsp_product, req0_ready, req1_ready, e[8], e[7:0]);
        end
      end
      ack;
    end
    scramble;
  endtask

  task automatic test_stall;
    bit ok, who, both;
    int w, lat;
    logic [8:0] e;
    logic [9:0] snap;
    drive(1, 4'b0111, 4'b0111);
    wait_accept(ok, who, both, w);
    sb.push_back({1'b1, 8'h31});
    scramble;
    req0_valid = 1'b1; req1_valid = 1'b1;
    wait_rsp(ok, lat);
    total++;
    if (sb.size() == 0) begin bad++; $display("FAIL stall_rsp: got no expected entry"); end
    else begin
      e = sb.pop_front();
      if (!ok || {rsp_id, rsp_product} !== e) begin
        bad++; $display("FAIL stall_rsp: got id=%0d prod=%h want id=%0d prod=%h", rsp_id, rsp_product, e[8], e[7:0]);
      end
    end
    snap = {1'b1, e};
    for (int k = 0; k < 10; k++) begin
      tick;
      total++;
      if ({rsp_valid, rsp_id, rsp_product} !== snap || req0_ready || req1_ready || !busy) begin
        bad++; $display("FAIL stall_hold%0d: got vld/id/prod=%h rdy=%b%b busy=%b want %h 00 1", k, {rsp_valid, rsp_id, rsp_product}, req0_ready, req1_ready, busy, snap);
      end
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    ack;
  endtask

  task automatic test_abort;
    bit ok, who, both, seen;
    int w, lat;
    logic [8:0] e;
    drive(0, 4'b0101, 4'b0011);
    wait_accept(ok, who, both, w);
    scramble;
    tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    total++;
    if (busy !== 1'b0 || rsp_valid !== 1'b0) begin
      bad++; $display("FAIL abort_idle: got busy=%b vld=%b want 0 0", busy, rsp_valid);
    end
    seen = 0;
    for (int k = 0; k < 8; k++) begin
      tick;
      if (rsp_valid) seen = 1;
    end
    total++;
    if (seen) begin bad++; $display("FAIL abort_norsp: got rsp_valid=1 want 0"); end
    drive(0, 4'b1111, 4'b0101);
    drive(1, 4'b0010, 4'b0010);
    #1;
    total++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      bad++; $display("FAIL abort_tie: got rdy0=%b rdy1=%b want 1 0", req0_ready, req1_ready);
    end
    wait_accept(ok, who, both, w);
    sb.push_back(who ? {1'b1, model(4'b0010, 4'b0010)} : {1'b0, model(4'b1111, 4'b0101)});
    scramble;
    wait_rsp(ok, lat);
    total++;
    if (sb.size() == 0) begin bad++; $display("FAIL abort_next: got no expected entry"); end
    else begin
      e = sb.pop_front();
      if (!ok || {rsp_id, rsp_product} !== e) begin
        bad++; $display("FAIL abort_next: got id=%0d prod=%h want id=%0d prod=%h", rsp_id, rsp_product, e[8], e[7:0]);
      end
    end
    ack;
  endtask

  task automatic test_exhaustive;
    bit ok, who, both;
    int w, lat;
    logic [8:0] e;
    logic [3:0] a, b;
    bit id;
    for (int i = 0; i < 256; i++) begin
      a = 4'(i >> 4);
      b = 4'(i);
      id = 1'($urandom);
      drive(id, a, b);
      wait_accept(ok, who, both, w);
      sb.push_back({id, model(a, b)});
      scramble;
      wait_rsp(ok, lat);
      total++;
      if (sb.size() == 0) begin bad++; $display("FAIL exh_%0d: got no expected entry", i); end
      else begin
        e = sb.pop_front();
        if (!ok || lat != 4 || {rsp_id, rsp_product} !== e || cycle_count !== EXP_CC) begin
          bad++; $display("FAIL exh_%0d: a=%h b=%h got lat=%0d id=%0d prod=%h cc=%0d want lat=4 id=%0d prod=%h cc=%0d", i, a, b, lat, rsp_id, rsp_product, cycle_count, e[8], e[7:0], EXP_CC);
        end
      end
      ack;
    end
  endtask

  initial begin
    rst = 1'b1; rsp_ready = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_mcand = '0; req0_mplier = '0; req1_mcand = '0; req1_mplier = '0;
    tick;
    test_reset;
    test_basic;
    test_req1;
    test_round_robin;
    test_stall;
    test_abort;
    test_exhaustive;
    total++;
    if (sb.size() != 0) begin bad++; $display("FAIL sb_drain: got %0d left want 0", sb.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/booth_mult_arbiter.md
BOOTH_MULT_ARBITER -- requirements
Module: booth_mult_arbiter

Interface
REQ-001 Shall have one clock and a synchronous active-high reset, named as in the codebase: clk (posedge) and rst.
REQ-002 clk  input  1  system clock; all state updates on posedge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 req0_valid / req1_valid  input  1  requester n holds operands valid.
REQ-005 req0_ready / req1_ready  output  1  block accepts requester n this cycle.
REQ-006 req0_mcand, req0_mplier, req1_mcand, req1_mplier  input  4  signed two's-complement operands.
REQ-007 rsp_valid  output  1  product available.
REQ-008 rsp_ready  input  1  consumer accepts product.
REQ-009 rsp_product  output  8  signed product.
REQ-010 rsp_id  output  1  requester index the product belongs to.
REQ-011 busy  output  1  high in every state except IDLE.
REQ-012 cycle_count  output  8  iteration cycles of the current/last operation (see Configuration).

Function
REQ-013 FSM states: IDLE, ITER, DONE.
REQ-014 IDLE: reqN_ready = 1 only for the granted requester, combinationally, and only when that requester's valid is high; at most one ready high per cycle.
REQ-015 Arbitration: round-robin on last_grant; one valid -> grant it; both valid -> grant the requester not equal to last_grant.
REQ-016 Handshake (valid & ready) in IDLE captures M = mcand, Q = mplier, A = 0, Q-1 = 0, count = 4, id = winner, last_grant = winner; next state ITER.
REQ-017 ITER, each cycle, radix-2 Booth step on {Q[0], Q-1}: 01 -> A+M; 10 -> A-M (add ~M with carry-in 1); 00/11 -> A unchanged; then arithmetic right shift of {A, Q, Q-1}; count decrements.
REQ-018 After exactly 4 ITER cycles, next state is DONE; rsp_valid rises 4 cycles after the accept edge.
REQ-019 rsp_product = {A, Q}; exact 8-bit signed result for all 256 operand pairs, including -8 * -8 = +64.
REQ-020 DONE: rsp_valid = 1; rsp_product and rsp_id hold stable until rsp_ready; on handshake, next state is IDLE.
REQ-021 The next request is accepted no earlier than the cycle after the response handshake; reqN_ready = 0 in ITER and DONE.
REQ-022 Operands are sampled only at the accept edge; later changes on the req buses do not affect the result.
REQ-023 rsp_valid, rsp_id and rsp_product do not change while rsp_valid = 1 and rsp_ready = 0.

Reset
REQ-024 rst at any posedge forces IDLE, rsp_valid = 0, reqN_ready = 0 in the following cycle, A/Q/M/Q-1 = 0, rsp_product = 0, rsp_id = 0, last_grant = 1 (req0 wins the first tie), cycle_count = 0.
REQ-025 Reset during ITER or DONE aborts the operation; no response is ever issued for it.

Configuration
REQ-026 Macro BOOTH_ARB_CYCLE_COUNT_EN defined: cycle_count clears on accept, increments once per ITER cycle, and holds (final value 4) until the next accept.
REQ-027 Macro undefined: the cycle_count port remains present and is tied to 0; there is no counter logic.

Structure
REQ-028 Package booth_arb_pkg holds the FSM state encoding, OP_W = 4, PROD_W = 8, and ITERATIONS = 4.
REQ-029 Sub-module booth_step implements the combinational A+M / A-M adder and shift for one iteration; the top contains the FSM, arbiter and handshakes.

Verification
REQ-030 Reset, then req0 with mplier 0110 and mcand 1010 -> accepted in the same cycle; rsp_valid 4 cycles later; product 1101_1100 (-36); rsp_id = 0.
REQ-031 req1 with mplier 0001 and mcand 1000 -> product 1111_1000 (-8), rsp_id = 1; then 1000 x 1000 -> 0100_0000 (+64).
REQ-032 Both valid continuously after reset -> grant order req0, req1, req0, req1; never two readys high in the same cycle.
REQ-033 rsp_ready held low for 10 cycles in DONE -> product, id and rsp_valid are stable; both readys stay 0; busy = 1.
REQ-034 rst asserted on the 2nd ITER cycle -> next cycle is IDLE, rsp_valid = 0, no response emitted; the next tie is won by req0.
REQ-035 With BOOTH_ARB_CYCLE_COUNT_EN: cycle_count = 4 at rsp_valid. Without it: cycle_count = 0 throughout.
